// File: rtl/gnr_pkg.sv
// Shared types for the GNR attractor detector and its host interface.
// Holds the FSM encoding, the default counter width and the result record.
package gnr_pkg;

  localparam int unsigned GNR_CNT_W   = 16;
  localparam int unsigned GNR_N_NODES = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    PERIOD,
    RESULT
  } gnr_state_e;

  typedef struct packed {
    logic [GNR_CNT_W-1:0]   meet;
    logic [GNR_CNT_W-1:0]   period;
    logic [GNR_N_NODES-1:0] state;
    logic                   timeout;
  } gnr_result_t;

endpackage

// File: rtl/gnr_attractor_detector.sv
// Floyd cycle detection over the GNR node array: sequences node init/stepping, finds x_k == x_2k, then the period.
// Result is held in RESULT until res_valid & res_ready; start is only honoured in IDLE.
module gnr_attractor_detector
  import gnr_pkg::*;
#(
  parameter int unsigned      N_NODES   = 32,
  parameter int unsigned      CNT_W     = GNR_CNT_W,
  parameter logic [CNT_W-1:0] MAX_STEPS = {CNT_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] state_s0,
  input  logic [N_NODES-1:0] state_s1,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_meet,
  output logic [CNT_W-1:0]   res_period,
  output logic [N_NODES-1:0] res_state,
  output logic               res_timeout
);

  gnr_state_e       state;
  gnr_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per;

  logic match;
  logic cmp_en;
  logic run_meet;
  logic run_tout;
  logic per_hit;
  logic per_tout;

  assign match = (state_s0 == state_s1);

  // Tortoise and hare are only aligned (x_k vs x_2k) after an even, non-zero step count.
  assign cmp_en   = !cnt[0] && (cnt != '0);
  assign run_meet = cmp_en && match;
  assign run_tout = !run_meet && (cnt == MAX_STEPS);
  assign per_hit  = (per != '0) && match;
  assign per_tout = !per_hit && (per == MAX_STEPS);

  assign busy      = (state != IDLE);
  assign res_valid = (state == RESULT);

  always_comb begin
    state_nxt = state;
    reset_nos = 1'b0;
    start_s0  = 1'b0;
    start_s1  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        reset_nos = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (run_meet) begin
          state_nxt = PERIOD;
        end else if (run_tout) begin
          state_nxt = RESULT;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
        end
      end
      PERIOD: begin
        if (per_hit || per_tout) begin
          state_nxt = RESULT;
        end else begin
          start_s1 = 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      per         <= '0;
      init_state  <= '0;
      res_meet    <= '0;
      res_period  <= '0;
      res_state   <= '0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            init_state  <= init_vec;
            cnt         <= '0;
            per         <= '0;
            res_meet    <= '0;
            res_period  <= '0;
            res_state   <= '0;
            res_timeout <= 1'b0;
          end
        end
        RUN: begin
          if (run_meet) begin
            res_meet  <= cnt >> 1;
            res_state <= state_s0;
          end else if (run_tout) begin
            res_timeout <= 1'b1;
            res_period  <= '0;
            res_meet    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PERIOD: begin
          if (per_hit) begin
            res_period <= per;
          end else if (per_tout) begin
            res_timeout <= 1'b1;
            res_period  <= '0;
            res_meet    <= '0;
          end else begin
            per <= per + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_attractor_detector.sv
// Bench for gnr_attractor_detector with a 4-node behavioural network (identity, rotate-left, increment).
// Expected results come from a direct Floyd reference and are queued at launch, compared at RESULT.
module tb_gnr_attractor_detector;

  localparam int unsigned NN   = 4;
  localparam int unsigned CW   = 16;
  localparam logic [CW-1:0] MAXS = 16'd20;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [NN-1:0] init_vec;
  logic [NN-1:0] s0 = '0;
  logic [NN-1:0] s1 = '0;
  logic          pass = 1'b0;
  logic          reset_nos;
  logic [NN-1:0] init_state;
  logic          start_s0;
  logic          start_s1;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_meet;
  logic [CW-1:0] res_period;
  logic [NN-1:0] res_state;
  logic          res_timeout;

  gnr_attractor_detector #(
    .N_NODES  (NN),
    .CNT_W    (CW),
    .MAX_STEPS(MAXS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .init_vec   (init_vec),
    .state_s0   (s0),
    .state_s1   (s1),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_meet   (res_meet),
    .res_period (res_period),
    .res_state  (res_state),
    .res_timeout(res_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int net_mode = 0;

  function automatic logic [NN-1:0] f_net(input int mode, input logic [NN-1:0] x);
    case (mode)
      0:       return x;
      1:       return {x[NN-2:0], x[NN-1]};
      default: return x + 4'd1;
    endcase
  endfunction

  // Node array with pass semantics: s0 advances on every second start_s0.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0   <= init_state;
      s1   <= init_state;
      pass <= 1'b0;
    end else begin
      if (start_s0) begin
        if (pass) s0 <= f_net(net_mode, s0);
        pass <= ~pass;
      end
      if (start_s1) s1 <= f_net(net_mode, s1);
    end
  end

  int rn_total   = 0;
  int step_total = 0;
  always @(negedge clk) begin
    if (reset_nos) rn_total++;
    if (start_s0 && start_s1) step_total++;
  end

  typedef struct {
    logic [CW-1:0] meet;
    logic [CW-1:0] period;
    logic [NN-1:0] state;
    logic          tout;
    int            steps;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rn0    = 0;
  int   st0    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input int mode, input logic [NN-1:0] x0);
    exp_t          e;
    logic [NN-1:0] t;
    logic [NN-1:0] h;
    int            k;
    int            p;
    bit            found;
    e.meet = '0; e.period = '0; e.state = '0; e.tout = 1'b0; e.steps = int'(MAXS);
    t = x0; h = x0; k = 0; found = 1'b0;
    while (!found && 2 * (k + 1) <= int'(MAXS)) begin
      k++;
      t = f_net(mode, t);
      h = f_net(mode, f_net(mode, h));
      if (t == h) found = 1'b1;
    end
    if (!found) begin
      e.tout = 1'b1;
      return e;
    end
    e.meet  = CW'(k);
    e.state = t;
    e.steps = 2 * k;
    h = t; p = 0; found = 1'b0;
    while (!found && p < int'(MAXS)) begin
      p++;
      h = f_net(mode, h);
      if (h == t) found = 1'b1;
    end
    if (found) begin
      e.period = CW'(p);
    end else begin
      e.tout = 1'b1;
      e.meet = '0;
    end
    return e;
  endfunction

  task automatic pulse_start(input logic [NN-1:0] v);
    init_vec = v;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic launch(input int mode, input logic [NN-1:0] v);
    net_mode = mode;
    sb.push_back(ref_model(mode, v));
    rn0 = rn_total;
    st0 = step_total;
    pulse_start(v);
  endtask

  task automatic wait_valid();
    int c = 0;
    while (!res_valid && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic finish_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_meet"},    32'(res_meet),    32'(e.meet));
    chk({tag, "_period"},  32'(res_period),  32'(e.period));
    chk({tag, "_timeout"}, 32'(res_timeout), 32'(e.tout));
    if (!e.tout) chk({tag, "_state"}, 32'(res_state), 32'(e.state));
    chk({tag, "_reset_nos_cycles"}, 32'(rn_total - rn0), 32'd1);
    chk({tag, "_hare_steps"}, 32'(step_total - st0), 32'(e.steps));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle_busy"},  32'(busy),      32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},        32'(busy),        32'd0);
    chk({tag, "_res_valid"},   32'(res_valid),   32'd0);
    chk({tag, "_reset_nos"},   32'(reset_nos),   32'd0);
    chk({tag, "_start_s0"},    32'(start_s0),    32'd0);
    chk({tag, "_start_s1"},    32'(start_s1),    32'd0);
    chk({tag, "_init_state"},  32'(init_state),  32'd0);
    chk({tag, "_res_meet"},    32'(res_meet),    32'd0);
    chk({tag, "_res_period"},  32'(res_period),  32'd0);
    chk({tag, "_res_state"},   32'(res_state),   32'd0);
    chk({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c;
    rst_n     = 1'b0;
    start     = 1'b0;
    res_ready = 1'b0;
    init_vec  = '0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Identity network: fixed point from the start.
    launch(0, 4'b1010);
    wait_valid();
    finish_result("identity");

    // Rotate-left: meets after 8 hare steps, period 4.
    launch(1, 4'b0001);
    wait_valid();
    finish_result("rotl");

    // Increment mod 16 times out at cnt=MAXS; result then held with ready low.
    launch(2, 4'b0000);
    wait_valid();
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      start    = (i == 1 || i == 3);
      init_vec = 4'b0111;
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid",   32'(res_valid),   32'd1);
      chk("hold_timeout", 32'(res_timeout), 32'(e.tout));
      chk("hold_meet",    32'(res_meet),    32'(e.meet));
      chk("hold_period",  32'(res_period),  32'(e.period));
      chk("hold_init",    32'(init_state),  32'd0);
    end
    finish_result("timeout");
    @(negedge clk);
    chk("post_hold_busy", 32'(busy), 32'd0);

    // Reset for one cycle at cnt=3 of a rotate run aborts it.
    net_mode = 1;
    pulse_start(4'b0001);
    chk("abort_init_cycle", 32'(reset_nos), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_running", 32'(start_s1 & start_s0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_result", 32'(res_valid), 32'd0);
    launch(0, 4'b0110);
    wait_valid();
    finish_result("after_abort");

    // Start pulses during RUN and PERIOD must be ignored.
    launch(1, 4'b0010);
    c = 0;
    while (!(start_s0 && start_s1) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("reach_run", 32'(start_s0 & start_s1), 32'd1);
    pulse_start(4'b1111);
    chk("run_start_init", 32'(init_state), 32'b0010);
    c = 0;
    while (!(start_s1 && !start_s0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("reach_period", 32'(start_s1 & ~start_s0), 32'd1);
    pulse_start(4'b1100);
    chk("period_start_init", 32'(init_state), 32'b0010);
    wait_valid();
    finish_result("ignore_start");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
